// File: rtl/uart_tx_cfg_if.sv
// Host-side frame handshake for uart_tx_cfg.
// The host (master) offers a frame with tx_valid/tx_data; the transmitter
// (slave) answers with tx_ready while it is idle.
interface uart_tx_cfg_if #(
   parameter int DATA_BITS = 8
) ();

   logic                 tx_valid;
   logic                 tx_ready;
   logic [DATA_BITS-1:0] tx_data;

   // Byte source side.
   modport master (
      output tx_valid,
      output tx_data,
      input  tx_ready
   );

   // Transmitter side.
   modport slave (
      input  tx_valid,
      input  tx_data,
      output tx_ready
   );

endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter.
// Sends start bit, DATA_BITS data bits LSB first, an optional even/odd parity
// bit and one or two stop bits. Every bit lasts CLKS_PER_BIT clocks. A frame is
// accepted on a clock edge where tx_valid && tx_ready; tx_ready is high only
// in IDLE, so back-to-back frames are separated by one idle-high cycle (the
// cycle that carries the done pulse).
module uart_tx_cfg #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_cfg_if.slave  tx_if,
   output logic          tx_out,
   output logic          start,
   output logic          busy,
   output logic          done
);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter guards
   // ------------------------------------------------------------------------
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be in 5..9");
   end
   if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
      $error("uart_tx_cfg: CLKS_PER_BIT must be at least 1");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end

   // ------------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------------
   // The baud counter only ever holds 0..CLKS_PER_BIT-1; keep at least one bit
   // so CLKS_PER_BIT=1 still has a (constant zero) counter.
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   // The bit counter indexes data bits 0..DATA_BITS-1 and is reused to count
   // stop bits; DATA_BITS>=5 so this is always wide enough for both.
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  LAST_DATA   = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  LAST_STOP   = BIT_W'(STOP_BITS - 1);
   localparam logic              ODD_BIT     = (PARITY_ODD != 0);
   localparam logic              HAS_PARITY  = (PARITY_EN != 0);

   // FSM encoding; codes 5..7 are unreachable and fall back to IDLE.
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   logic [2:0]           state,      state_nxt;
   logic [BAUD_W-1:0]    baud_cnt,   baud_nxt;
   logic [BIT_W-1:0]     bit_cnt,    bit_nxt;
   logic [DATA_BITS-1:0] shift_reg,  shift_nxt;
   logic                 parity_bit, parity_nxt;
   logic                 tx_out_nxt;
   logic                 start_nxt;
   logic                 busy_nxt;
   logic                 done_nxt;

   logic                 baud_zero;

   assign baud_zero      = (baud_cnt == '0);

   // Ready is a pure function of the state so the host sees it in the same
   // cycle the transmitter returns to IDLE (the done cycle).
   assign tx_if.tx_ready = (state == S_IDLE);

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path leaves
      // a value unassigned and no latch is inferred; blocking assignments are
      // correct here because this block models combinational logic only.
      state_nxt  = state;
      baud_nxt   = baud_cnt;
      bit_nxt    = bit_cnt;
      shift_nxt  = shift_reg;
      parity_nxt = parity_bit;
      start_nxt  = 1'b0;
      done_nxt   = 1'b0;

      case (state)
         S_IDLE: begin
            if (tx_if.tx_valid) begin
               // Accept: capture payload and its parity; later tx_data changes
               // cannot touch the frame in flight.
               shift_nxt  = tx_if.tx_data;
               parity_nxt = (^tx_if.tx_data) ^ ODD_BIT;
               state_nxt  = S_START;
               baud_nxt   = BAUD_RELOAD;
               bit_nxt    = '0;
               start_nxt  = 1'b1;
            end
         end

         S_START: begin
            if (baud_zero) begin
               state_nxt = S_DATA;
               baud_nxt  = BAUD_RELOAD;
               bit_nxt   = '0;
            end else begin
               baud_nxt  = baud_cnt - 1'b1;
            end
         end

         S_DATA: begin
            if (baud_zero) begin
               baud_nxt  = BAUD_RELOAD;
               shift_nxt = shift_reg >> 1;
               if (bit_cnt == LAST_DATA) begin
                  state_nxt = HAS_PARITY ? S_PARITY : S_STOP;
                  bit_nxt   = '0;
               end else begin
                  bit_nxt   = bit_cnt + 1'b1;
               end
            end else begin
               baud_nxt  = baud_cnt - 1'b1;
            end
         end

         S_PARITY: begin
            if (baud_zero) begin
               state_nxt = S_STOP;
               baud_nxt  = BAUD_RELOAD;
               bit_nxt   = '0;
            end else begin
               baud_nxt  = baud_cnt - 1'b1;
            end
         end

         S_STOP: begin
            if (baud_zero) begin
               if (bit_cnt == LAST_STOP) begin
                  state_nxt = S_IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  bit_nxt   = bit_cnt + 1'b1;
                  baud_nxt  = BAUD_RELOAD;
               end
            end else begin
               baud_nxt  = baud_cnt - 1'b1;
            end
         end

         default: begin
            // Corrupted state register: return to a quiet, idle line.
            state_nxt = S_IDLE;
            baud_nxt  = '0;
            bit_nxt   = '0;
         end
      endcase

      // The line level is registered and derived from the state being
      // entered, so tx_out changes exactly on bit boundaries without glitches.
      case (state_nxt)
         S_START:  tx_out_nxt = 1'b0;
         S_DATA:   tx_out_nxt = shift_nxt[0];
         S_PARITY: tx_out_nxt = parity_nxt;
         default:  tx_out_nxt = 1'b1;
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

   // Sequencer registers with asynchronous, active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge, independent of statement
      // order.
      if (reset) begin
         // NOTE: the shift register is a datapath register, but it is cleared
         // too so a reset leaves no trace of an aborted payload.
         state      <= S_IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         tx_out     <= 1'b1;
         start      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         baud_cnt   <= baud_nxt;
         bit_cnt    <= bit_nxt;
         shift_reg  <= shift_nxt;
         parity_bit <= parity_nxt;
         tx_out     <= tx_out_nxt;
         start      <= start_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg.
// Six transmitters with different configurations share one clock and reset.
// A reference model derives the expected line level of any cycle of a frame
// directly from the frame layout (start, data LSB first, parity, stops), and
// every cycle of every frame is compared against it together with the
// start/busy/done/ready flags.
module tb_uart_tx_cfg;

   localparam int NDUT = 6;

   //                                   base  even  odd  2stop narrow wide
   localparam int CFG_DB  [NDUT] = '{   8,    8,    8,   8,    7,     9 };
   localparam int CFG_CPB [NDUT] = '{   4,    4,    4,   4,    1,     3 };
   localparam int CFG_PE  [NDUT] = '{   0,    1,    1,   0,    1,     1 };
   localparam int CFG_PO  [NDUT] = '{   0,    0,    1,   0,    1,     0 };
   localparam int CFG_SB  [NDUT] = '{   1,    1,    1,   2,    1,     2 };

   logic            clk;
   logic            reset;
   logic [NDUT-1:0] valid_r;
   logic [8:0]      data_r [NDUT];
   logic [NDUT-1:0] ready_w;
   logic [NDUT-1:0] tx_out_w;
   logic [NDUT-1:0] start_w;
   logic [NDUT-1:0] busy_w;
   logic [NDUT-1:0] done_w;

   int n_cmp = 0;
   int n_err = 0;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      uart_tx_cfg_if #(.DATA_BITS(CFG_DB[g])) bus ();

      assign bus.tx_valid = valid_r[g];
      assign bus.tx_data  = data_r[g][CFG_DB[g]-1:0];
      assign ready_w[g]   = bus.tx_ready;

      uart_tx_cfg #(
         .DATA_BITS    (CFG_DB[g]),
         .CLKS_PER_BIT (CFG_CPB[g]),
         .PARITY_EN    (CFG_PE[g]),
         .PARITY_ODD   (CFG_PO[g]),
         .STOP_BITS    (CFG_SB[g])
      ) dut (
         .clk    (clk),
         .reset  (reset),
         .tx_if  (bus),
         .tx_out (tx_out_w[g]),
         .start  (start_w[g]),
         .busy   (busy_w[g]),
         .done   (done_w[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------
   function automatic int frame_span(input int d);
      return (1 + CFG_DB[d] + CFG_PE[d] + CFG_SB[d]) * CFG_CPB[d];
   endfunction

   // Expected line level in cycle j (j=1 is the first cycle after accept).
   function automatic logic exp_line(input int d, input logic [8:0] data, input int j);
      int   db;
      int   idx;
      logic par;
      db = CFG_DB[d];
      if (j < 1 || j > frame_span(d)) return 1'b1;
      idx = (j - 1) / CFG_CPB[d];
      if (idx == 0) return 1'b0;
      if (idx <= db) return data[idx-1];
      if (CFG_PE[d] != 0 && idx == db + 1) begin
         par = (CFG_PO[d] != 0);
         for (int i = 0; i < db; i++) par = par ^ data[i];
         return par;
      end
      return 1'b1;
   endfunction

   // Compare all outputs of DUT d in frame cycle j.
   task automatic check_cycle(input int d, input logic [8:0] data, input int j);
      int span;
      span = frame_span(d);
      check($sformatf("d%0d c%0d tx_out", d, j), 32'(tx_out_w[d]), 32'(exp_line(d, data, j)));
      check($sformatf("d%0d c%0d start",  d, j), 32'(start_w[d]),  32'(j == 1));
      check($sformatf("d%0d c%0d busy",   d, j), 32'(busy_w[d]),   32'(j <= span));
      check($sformatf("d%0d c%0d done",   d, j), 32'(done_w[d]),   32'(j == span + 1));
      check($sformatf("d%0d c%0d ready",  d, j), 32'(ready_w[d]),  32'(j == span + 1));
   endtask

   // Send one frame on DUT d and check it cycle by cycle through the done
   // cycle. preacc: the accept was already set up by a chained predecessor.
   // chain: keep tx_valid high with next_data so the next frame is accepted
   // straight out of the done cycle. Otherwise tx_valid/tx_data are wiggled
   // randomly while busy (they must be ignored) and dropped in the done cycle.
   task automatic run_frame(input int d, input logic [8:0] data,
                            input bit preacc, input bit chain, input logic [8:0] next_data);
      int span;
      span = frame_span(d);
      if (!preacc) begin
         @(negedge clk);
         check($sformatf("d%0d idle ready", d), 32'(ready_w[d]), 32'd1);
         valid_r[d] = 1'b1;
         data_r[d]  = data;
      end
      for (int j = 1; j <= span + 1; j++) begin
         @(negedge clk);
         check_cycle(d, data, j);
         if (chain) begin
            valid_r[d] = 1'b1;
            data_r[d]  = next_data;
         end else if (j == span + 1) begin
            valid_r[d] = 1'b0;
         end else begin
            valid_r[d] = 1'($urandom_range(0, 1));
            data_r[d]  = 9'($urandom);
         end
      end
   endtask

   // Start a frame, assert reset in frame cycle abort_j, and check that the
   // frame is dropped at once and never reports done.
   task automatic run_abort(input int d, input logic [8:0] data, input int abort_j);
      @(negedge clk);
      valid_r[d] = 1'b1;
      data_r[d]  = data;
      for (int j = 1; j <= abort_j; j++) begin
         @(negedge clk);
         valid_r[d] = 1'b0;
         check($sformatf("d%0d pre-abort c%0d tx_out", d, j), 32'(tx_out_w[d]), 32'(exp_line(d, data, j)));
      end
      reset = 1'b1;
      #1;
      check("abort tx_out", 32'(tx_out_w[d]), 32'd1);
      check("abort busy",   32'(busy_w[d]),   32'd0);
      check("abort ready",  32'(ready_w[d]),  32'd1);
      check("abort done",   32'(done_w[d]),   32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int j = 0; j < frame_span(d) + 4; j++) begin
         @(negedge clk);
         check($sformatf("post-abort c%0d done", j),   32'(done_w[d]),   32'd0);
         check($sformatf("post-abort c%0d tx_out", j), 32'(tx_out_w[d]), 32'd1);
         check($sformatf("post-abort c%0d busy", j),   32'(busy_w[d]),   32'd0);
      end
   endtask

   // Main sequence.
   initial begin
      int         d;
      logic [8:0] a;
      logic [8:0] b;

      reset   = 1'b1;
      valid_r = '0;
      for (int i = 0; i < NDUT; i++) data_r[i] = '0;

      repeat (3) @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("d%0d rst tx_out", i), 32'(tx_out_w[i]), 32'd1);
         check($sformatf("d%0d rst busy", i),   32'(busy_w[i]),   32'd0);
         check($sformatf("d%0d rst start", i),  32'(start_w[i]),  32'd0);
         check($sformatf("d%0d rst done", i),   32'(done_w[i]),   32'd0);
      end
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NDUT; i++)
         check($sformatf("d%0d post-rst ready", i), 32'(ready_w[i]), 32'd1);

      // Directed frames from the block's intended use.
      run_frame(0, 9'h0A5, 1'b0, 1'b0, 9'h000);   // base 8N1
      run_frame(1, 9'h007, 1'b0, 1'b0, 9'h000);   // even parity -> 1
      run_frame(2, 9'h007, 1'b0, 1'b0, 9'h000);   // odd parity -> 0
      run_frame(1, 9'h000, 1'b0, 1'b0, 9'h000);   // even parity -> 0
      run_frame(3, 9'h0FF, 1'b0, 1'b0, 9'h000);   // two stop bits
      run_frame(0, 9'h055, 1'b0, 1'b1, 9'h0AA);   // back-to-back pair
      run_frame(0, 9'h0AA, 1'b1, 1'b0, 9'h000);
      run_abort(0, 9'h03C, 18);                   // reset in data bit 3
      run_frame(0, 9'h081, 1'b0, 1'b0, 9'h000);
      run_frame(4, 9'h07F, 1'b0, 1'b0, 9'h000);   // 7 bits, 1 clk/bit, odd
      run_frame(5, 9'h1FF, 1'b0, 1'b0, 9'h000);   // full 9-bit payload
      run_frame(5, 9'h100, 1'b0, 1'b0, 9'h000);

      // Random frames on random configurations.
      repeat (30) begin
         d = int'($urandom_range(0, NDUT - 1));
         run_frame(d, 9'($urandom), 1'b0, 1'b0, 9'h000);
      end

      // Random back-to-back pairs.
      repeat (4) begin
         d = int'($urandom_range(0, NDUT - 1));
         a = 9'($urandom);
         b = 9'($urandom);
         run_frame(d, a, 1'b0, 1'b1, b);
         run_frame(d, b, 1'b1, 1'b0, 9'h000);
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
